// File: rtl/projeto_bobc_if.sv
// Requester-side bus of the quadratic evaluator: start/acknowledge handshake,
// operands, and the registered result with its valid LED.
interface projeto_bobc_if #(parameter int WIDTH = 16);
    logic             inicio;
    logic             pronto;
    logic [WIDTH-1:0] X;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] C;
    logic [WIDTH-1:0] Resultado;
    logic             LED;

    modport master (output inicio, pronto, X, A, B, C, input Resultado, LED);
    modport slave  (input inicio, pronto, X, A, B, C, output Resultado, LED);
endinterface

// File: rtl/projeto_bobc.sv
// Sequential evaluator of A*X^2 + B*X + C (modulo 2^WIDTH) built from one shared
// multiplier and one shared adder, sequenced by a six-step FSM plus a DONE hold state.
module projeto_bobc #(
    parameter int WIDTH = 16
) (
    input  logic           ck,
    input  logic           rst,
    projeto_bobc_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, MXX, MA, MB, AD1, AD2, DONE} state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] rx_reg, ra_reg, rb_reg, rc_reg;
    logic [WIDTH-1:0] r1_reg, r2_reg, rres_reg;
    logic             led_reg;

    logic [WIDTH-1:0] mul_a, mul_b, add_a, add_b;
    logic [WIDTH-1:0] prod, sum;

    // Operand steering for the shared arithmetic units.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        add_a = '0;
        add_b = '0;
        case (state_reg)
            MXX: begin mul_a = rx_reg; mul_b = rx_reg; end
            MA:  begin mul_a = ra_reg; mul_b = r1_reg; end
            MB:  begin mul_a = rb_reg; mul_b = rx_reg; end
            AD1: begin add_a = r1_reg; add_b = r2_reg; end
            AD2: begin add_a = r1_reg; add_b = rc_reg; end
            default: ;
        endcase
    end

    // Only the low WIDTH bits of product and sum are kept.
    assign prod = mul_a * mul_b;
    assign sum  = add_a + add_b;

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            rx_reg    <= '0;
            ra_reg    <= '0;
            rb_reg    <= '0;
            rc_reg    <= '0;
            r1_reg    <= '0;
            r2_reg    <= '0;
            rres_reg  <= '0;
            led_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.inicio) begin
                        rx_reg    <= bus.X;
                        ra_reg    <= bus.A;
                        rb_reg    <= bus.B;
                        rc_reg    <= bus.C;
                        state_reg <= MXX;
                    end
                end
                MXX: begin
                    r1_reg    <= prod;
                    state_reg <= MA;
                end
                MA: begin
                    r1_reg    <= prod;
                    state_reg <= MB;
                end
                MB: begin
                    r2_reg    <= prod;
                    state_reg <= AD1;
                end
                AD1: begin
                    r1_reg    <= sum;
                    state_reg <= AD2;
                end
                AD2: begin
                    rres_reg  <= sum;
                    led_reg   <= 1'b1;
                    state_reg <= DONE;
                end
                DONE: begin
                    if (bus.pronto) begin
                        led_reg   <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.Resultado = rres_reg;
    assign bus.LED       = led_reg;
endmodule

// File: tb/tb_projeto_bobc.sv
// Scoreboard bench for projeto_bobc: stimulus pushes expected results computed
// from the polynomial, a negedge monitor pops and compares on each LED rise.
module tb_projeto_bobc;
    localparam int WIDTH = 16;

    logic ck;
    logic rst;
    projeto_bobc_if #(.WIDTH(WIDTH)) bus ();

    projeto_bobc #(.WIDTH(WIDTH)) dut (
        .ck  (ck),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [WIDTH-1:0] sb[$];
    logic [WIDTH-1:0] last_exp;
    logic led_prev;

    initial begin
        ck = 1'b0;
        forever #5 ck = ~ck;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running required finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d at %0t", name, act, exp, $time);
        end else begin
            $display("ok   %s: %0d at %0t", name, act, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] x, a, b, c);
        longint unsigned v;
        v = longint'(a) * longint'(x) * longint'(x) + longint'(b) * longint'(x) + longint'(c);
        return WIDTH'(v % (64'd1 << WIDTH));
    endfunction

    // Monitor: every rising LED is a presented result.
    initial begin
        led_prev = 1'b0;
        forever begin
            @(negedge ck);
            if (rst) begin
                led_prev = 1'b0;
            end else begin
                if (bus.LED && !led_prev) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_result", {16'd0, bus.Resultado}, 32'hFFFF_FFFF);
                    end else begin
                        chk("result", {16'd0, bus.Resultado}, {16'd0, sb.pop_front()});
                    end
                end
                led_prev = bus.LED;
            end
        end
    end

    // Drive operands and inicio, sample edge E0, drop inicio.
    task automatic start_calc(input logic [WIDTH-1:0] x, a, b, c);
        @(negedge ck);
        bus.X = x; bus.A = a; bus.B = b; bus.C = c;
        bus.inicio = 1'b1;
        last_exp = model(x, a, b, c);
        sb.push_back(last_exp);
        @(posedge ck);
        #1 bus.inicio = 1'b0;
    endtask

    // LED must be low after E1..E4 and high after E5.
    task automatic check_latency(input int from_edge);
        for (int k = from_edge; k <= 5; k++) begin
            @(posedge ck);
            #1;
            chk($sformatf("led_after_E%0d", k), {31'd0, bus.LED}, {31'd0, (k == 5)});
        end
    endtask

    task automatic ack(input int hold);
        for (int k = 0; k < hold; k++) begin
            @(posedge ck);
            #1 chk("led_held", {31'd0, bus.LED}, 32'd1);
        end
        @(negedge ck);
        bus.pronto = 1'b1;
        @(posedge ck);
        #1;
        chk("led_after_ack", {31'd0, bus.LED}, 32'd0);
        chk("result_hold", {16'd0, bus.Resultado}, {16'd0, last_exp});
        bus.pronto = 1'b0;
    endtask

    initial begin
        bus.inicio = 1'b0; bus.pronto = 1'b0;
        bus.X = '0; bus.A = '0; bus.B = '0; bus.C = '0;
        rst = 1'b1;
        #1;
        chk("reset_led", {31'd0, bus.LED}, 32'd0);
        chk("reset_result", {16'd0, bus.Resultado}, 32'd0);
        #20;
        @(negedge ck);
        rst = 1'b0;

        // Basic case, inicio held for two cycles (second sample lands in MXX).
        @(negedge ck);
        bus.X = 16'd2; bus.A = 16'd1; bus.B = 16'd3; bus.C = 16'd4;
        bus.inicio = 1'b1;
        last_exp = 16'd14;
        sb.push_back(last_exp);
        @(posedge ck);
        @(posedge ck);
        #1 bus.inicio = 1'b0;
        chk("led_after_E1", {31'd0, bus.LED}, 32'd0);
        check_latency(2);
        ack(3);

        start_calc(16'd0, 16'd7, 16'd9, 16'd5);
        check_latency(1);
        ack(0);
        start_calc(16'd3, 16'd2, 16'd0, 16'd1);
        check_latency(1);
        ack(1);
        chk("expect_19", {16'd0, last_exp}, 32'd19);

        start_calc(16'd300, 16'd1, 16'd0, 16'd0);
        check_latency(1);
        ack(0);
        chk("expect_24464", {16'd0, last_exp}, 32'd24464);
        start_calc(16'hFFFF, 16'd1, 16'd1, 16'd1);
        check_latency(1);
        ack(0);

        // Operand and inicio change during MA must not disturb the run.
        start_calc(16'd2, 16'd1, 16'd3, 16'd4);
        @(posedge ck);
        #1 chk("mid_led_E1", {31'd0, bus.LED}, 32'd0);
        bus.X = 16'd9; bus.inicio = 1'b1;
        @(posedge ck);
        #1 chk("mid_led_E2", {31'd0, bus.LED}, 32'd0);
        bus.inicio = 1'b0;
        check_latency(3);
        ack(1);
        chk("mid_result_14", {16'd0, bus.Resultado}, 32'd14);

        // Asynchronous reset during AD1.
        start_calc(16'd5, 16'd6, 16'd7, 16'd8);
        repeat (3) @(posedge ck);
        #2 rst = 1'b1;
        void'(sb.pop_back());
        #1;
        chk("async_rst_led", {31'd0, bus.LED}, 32'd0);
        chk("async_rst_result", {16'd0, bus.Resultado}, 32'd0);
        @(negedge ck);
        rst = 1'b0;
        start_calc(16'd5, 16'd6, 16'd7, 16'd8);
        check_latency(1);
        ack(0);

        // pronto held high: LED lasts exactly one cycle, pronto in IDLE is inert.
        @(negedge ck);
        bus.pronto = 1'b1;
        start_calc(16'd10, 16'd3, 16'd2, 16'd1);
        check_latency(1);
        @(posedge ck);
        #1 chk("pronto_led_one_cycle", {31'd0, bus.LED}, 32'd0);
        repeat (3) begin
            @(posedge ck);
            #1 chk("pronto_idle_led", {31'd0, bus.LED}, 32'd0);
        end
        chk("pronto_idle_result", {16'd0, bus.Resultado}, {16'd0, last_exp});
        bus.pronto = 1'b0;

        // Randomized runs with random acknowledge delay.
        for (int i = 0; i < 20; i++) begin
            start_calc(WIDTH'($urandom), WIDTH'($urandom), WIDTH'($urandom), WIDTH'($urandom));
            check_latency(1);
            ack(int'($urandom_range(0, 3)));
        end

        repeat (2) @(negedge ck);
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
